// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the "no writeback" destination select.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } sizeE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } stateE;

    localparam logic [31:0] DSEL_NONE = 32'h0000_0001;

    // Memory op captured from EX_MEM when the request is issued.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dsel;
        sizeE        size;
        logic        load;
        logic        store;
        logic        uns;
    } memOpT;

    function automatic logic isAligned(input sizeE size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: isAligned = 1'b1;
            SZ_HALF: isAligned = ~lane[0];
            SZ_WORD: isAligned = (lane == 2'b00);
            default: isAligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and
// the data memory.
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_stage_lane_fmt.sv
// Little-endian lane formatting: store data replication with byte enables,
// and load lane selection with sign/zero extension.
module mem_lane_fmt
    import mem_access_stage_pkg::*;
(
    input  sizeE        stSize,
    input  logic [1:0]  stLane,
    input  logic [31:0] stData,
    output logic [3:0]  stBe,
    output logic [31:0] stWord,
    input  sizeE        ldSize,
    input  logic [1:0]  ldLane,
    input  logic        ldUnsigned,
    input  logic [31:0] ldWord,
    output logic [31:0] ldData
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        stBe   = 4'b1111;
        stWord = stData;
        case (stSize)
            SZ_BYTE: begin
                stBe   = 4'b0001 << stLane;
                stWord = {4{stData[7:0]}};
            end
            SZ_HALF: begin
                stBe   = 4'b0011 << stLane;
                stWord = {2{stData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ldLane)
            2'd0:    ldByte = ldWord[7:0];
            2'd1:    ldByte = ldWord[15:8];
            2'd2:    ldByte = ldWord[23:16];
            default: ldByte = ldWord[31:24];
        endcase
        ldHalf = ldLane[1] ? ldWord[31:16] : ldWord[15:0];
    end

    always_comb begin
        ldData = ldWord;
        case (ldSize)
            SZ_BYTE: ldData = {{24{ldByte[7] & ~ldUnsigned}}, ldByte};
            SZ_HALF: ldData = {{16{ldHalf[15] & ~ldUnsigned}}, ldHalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage between EX_MEM and MEM_WB: runs the data-memory
// handshake, stalls upstream while an access is outstanding, flags errors.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic [1:0]          ex_size,
    input  logic                ex_unsigned,
    input  logic [31:0]         ex_addr,
    input  logic [31:0]         ex_wdata,
    input  logic [31:0]         ex_dsel,
    mem_access_stage_if.master  bus,
    output logic [31:0]         dbus_out,
    output logic [31:0]         databus_out,
    output logic [31:0]         dsel_out,
    output logic                load_out,
    output logic                store_out,
    output logic                stall,
    output logic                misalign_err,
    output logic                bus_err
);

    stateE             stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    memOpT             opQ;
    logic [31:0]       memAddrQ, memWdataQ;
    logic [3:0]        memBeQ;

    sizeE              exSize;
    logic              exMem, exAligned, tcHit, accept;
    logic [3:0]        fmtBe;
    logic [31:0]       fmtWdata, fmtLoad;

    logic [31:0]       dbusD, databusD, dselD;
    logic              loadD, storeD, misD, busErrD;

    assign exSize    = sizeE'(ex_size);
    assign exMem     = ex_valid && (ex_load || ex_store);
    assign exAligned = isAligned(exSize, ex_addr[1:0]);
    assign tcHit     = (cntQ == CNT_W'(TIMEOUT - 1));

    mem_lane_fmt uFmt (
        .stSize     (exSize),
        .stLane     (ex_addr[1:0]),
        .stData     (ex_wdata),
        .stBe       (fmtBe),
        .stWord     (fmtWdata),
        .ldSize     (opQ.size),
        .ldLane     (opQ.addr[1:0]),
        .ldUnsigned (opQ.uns),
        .ldWord     (bus.mem_rdata),
        .ldData     (fmtLoad)
    );

    // Request, write strobe and bus fields all follow the state register.
    assign bus.mem_req   = (stateQ == ST_REQ);
    assign bus.mem_we    = (stateQ == ST_REQ) && opQ.store;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_be    = memBeQ;
    assign bus.mem_wdata = memWdataQ;

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accept   = 1'b0;
        stall    = 1'b0;
        dbusD    = ex_addr;
        databusD = ex_wdata;
        dselD    = DSEL_NONE;
        loadD    = 1'b0;
        storeD   = 1'b0;
        misD     = 1'b0;
        busErrD  = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (ex_valid && !(ex_load || ex_store)) begin
                    dselD = ex_dsel;
                end else if (exMem) begin
                    if (exAligned) begin
                        stall  = 1'b1;
                        accept = 1'b1;
                        cntD   = '0;
                        stateD = ST_REQ;
                    end else begin
                        misD = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                dbusD    = opQ.addr;
                databusD = opQ.wdata;
                // An ack in the terminal-count cycle still completes the access.
                if (bus.mem_ack) begin
                    stateD   = ST_IDLE;
                    databusD = opQ.load ? fmtLoad : opQ.wdata;
                    dselD    = opQ.dsel;
                    loadD    = opQ.load;
                    storeD   = opQ.store;
                end else if (tcHit) begin
                    stateD  = ST_IDLE;
                    busErrD = 1'b1;
                end else begin
                    stall = 1'b1;
                    cntD  = cntQ + CNT_W'(1);
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= ST_IDLE;
            cntQ         <= '0;
            opQ          <= '0;
            memAddrQ     <= '0;
            memBeQ       <= '0;
            memWdataQ    <= '0;
            dbus_out     <= '0;
            databus_out  <= '0;
            dsel_out     <= DSEL_NONE;
            load_out     <= 1'b0;
            store_out    <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            stateQ       <= stateD;
            cntQ         <= cntD;
            dbus_out     <= dbusD;
            databus_out  <= databusD;
            dsel_out     <= dselD;
            load_out     <= loadD;
            store_out    <= storeD;
            misalign_err <= misD;
            bus_err      <= busErrD;
            if (accept) begin
                opQ.addr  <= ex_addr;
                opQ.wdata <= ex_wdata;
                opQ.dsel  <= ex_dsel;
                opQ.size  <= exSize;
                opQ.load  <= ex_load;
                opQ.store <= ex_store && !ex_load;
                opQ.uns   <= ex_unsigned;
                memAddrQ  <= {ex_addr[31:2], 2'b00};
                memBeQ    <= fmtBe;
                memWdataQ <= fmtWdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model of
// alignment, byte enables, lane data and stall/timeout timing.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_load, ex_store, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata, ex_dsel;
    logic [31:0] dbus_out, databus_out, dsel_out;
    logic        load_out, store_out, stall, misalign_err, bus_err;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic        load;
        logic        store;
        logic        uns;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dsel;
        logic [31:0] rdata;
        int          ackDelay;
    } opT;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_load      (ex_load),
        .ex_store     (ex_store),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_dsel      (ex_dsel),
        .bus          (bus.master),
        .dbus_out     (dbus_out),
        .databus_out  (databus_out),
        .dsel_out     (dsel_out),
        .load_out     (load_out),
        .store_out    (store_out),
        .stall        (stall),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit mAligned(input logic [1:0] size, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return (lane % 2) == 0;
            2'd2:    return lane == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] mBe(input logic [1:0] size, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        case (size)
            2'd0:    return 4'(1 << lane);
            2'd1:    return 4'(3 << lane);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] mStoreData(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    return (wdata & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wdata & 32'hFFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] mLoadData(input logic [1:0] size, input logic [31:0] addr,
                                              input logic uns, input logic [31:0] rdata);
        logic [31:0] mask, v;
        int lane;
        lane = int'(addr % 4);
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        v = (rdata >> (8 * lane)) & mask;
        if (!uns && size != 2'd2 && v > (mask >> 1)) v = v - mask - 32'd1;
        return v;
    endfunction

    task automatic driveBubble();
        ex_valid    = 1'b0;
        ex_load     = 1'b0;
        ex_store    = 1'b0;
        ex_size     = 2'($urandom_range(0, 3));
        ex_unsigned = 1'($urandom_range(0, 1));
        ex_addr     = $urandom;
        ex_wdata    = $urandom;
        ex_dsel     = $urandom;
    endtask

    task automatic runAlu(input logic valid, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] dsel);
        @(negedge clk);
        ex_valid    = valid;
        ex_load     = 1'b0;
        ex_store    = 1'b0;
        ex_size     = 2'($urandom_range(0, 3));
        ex_unsigned = 1'($urandom_range(0, 1));
        ex_addr     = addr;
        ex_wdata    = wdata;
        ex_dsel     = dsel;
        bus.mem_ack = 1'($urandom_range(0, 1));
        #1;
        chk("alu_stall", stall, 0);
        chk("alu_req", bus.mem_req, 0);
        @(negedge clk);
        driveBubble();
        bus.mem_ack = 1'b0;
        #1;
        chk("alu_dsel", dsel_out, valid ? dsel : 32'h1);
        chk("alu_ldst", {load_out, store_out}, 0);
        chk("alu_err", {misalign_err, bus_err}, 0);
        if (valid) begin
            chk("alu_dbus", dbus_out, addr);
            chk("alu_databus", databus_out, wdata);
        end
    endtask

    task automatic runOp(input opT op);
        bit al, acked;
        int stalls, expStalls;
        al     = mAligned(op.size, op.addr);
        acked  = 1'b0;
        stalls = 0;
        @(negedge clk);
        ex_valid    = 1'b1;
        ex_load     = op.load;
        ex_store    = op.store;
        ex_size     = op.size;
        ex_unsigned = op.uns;
        ex_addr     = op.addr;
        ex_wdata    = op.wdata;
        ex_dsel     = op.dsel;
        bus.mem_ack = 1'b0;
        #1;
        chk("prev_err_cleared", {misalign_err, bus_err}, 0);
        chk("accept_stall", stall, al);
        chk("accept_req", bus.mem_req, 0);
        stalls += int'(stall);
        if (al) begin
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                if (k == op.ackDelay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = op.rdata;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
                #1;
                chk("req_active", bus.mem_req, 1);
                chk("req_we", bus.mem_we, op.store);
                chk("req_addr", bus.mem_addr, op.addr & 32'hFFFF_FFFC);
                chk("req_be", bus.mem_be, mBe(op.size, op.addr));
                chk("req_wdata", bus.mem_wdata, mStoreData(op.size, op.wdata));
                chk("req_bubble", {dsel_out, 1'b0, load_out, store_out}, {32'h1, 3'b000});
                chk("req_stall", stall, (k != op.ackDelay) && (k != TO - 1));
                stalls += int'(stall);
                if (k == op.ackDelay) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        @(negedge clk);
        driveBubble();
        bus.mem_ack = 1'($urandom_range(0, 1));
        #1;
        expStalls = !al ? 0 : 1 + ((op.ackDelay < TO - 1) ? op.ackDelay : TO - 1);
        chk("req_dropped", bus.mem_req, 0);
        chk("stall_cycles", stalls, expStalls);
        if (!al) begin
            chk("mis_err", {misalign_err, bus_err}, 2'b10);
            chk("mis_dsel", dsel_out, 32'h1);
            chk("mis_ldst", {load_out, store_out}, 0);
            chk("mis_dbus", dbus_out, op.addr);
        end else if (acked) begin
            chk("ack_err", {misalign_err, bus_err}, 0);
            chk("ack_dbus", dbus_out, op.addr);
            chk("ack_dsel", dsel_out, op.dsel);
            chk("ack_ldst", {load_out, store_out}, {op.load, op.store});
            chk("ack_databus", databus_out,
                op.load ? mLoadData(op.size, op.addr, op.uns, op.rdata) : op.wdata);
        end else begin
            chk("to_err", {misalign_err, bus_err}, 2'b01);
            chk("to_dsel", dsel_out, 32'h1);
            chk("to_ldst", {load_out, store_out}, 0);
        end
    endtask

    function automatic opT mkOp(input logic ld, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ackDelay);
        opT o;
        o.load     = ld;
        o.store    = !ld;
        o.uns      = uns;
        o.size     = size;
        o.addr     = addr;
        o.wdata    = wdata;
        o.dsel     = 32'h1 << $urandom_range(1, 31);
        o.rdata    = rdata;
        o.ackDelay = ackDelay;
        return o;
    endfunction

    initial begin
        opT o;
        int kind;
        reset = 1'b1;
        driveBubble();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_we", {bus.mem_req, bus.mem_we}, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_dbus", dbus_out, 0);
        chk("rst_databus", databus_out, 0);
        chk("rst_dsel", dsel_out, 32'h1);
        chk("rst_flags", {load_out, store_out, misalign_err, bus_err}, 0);
        reset = 1'b0;

        runAlu(1'b1, 32'h0000_1234, 32'h5555_AAAA, 32'h0000_0008);
        runAlu(1'b0, 32'h0000_0040, 32'h1111_2222, 32'h0000_0010);
        runOp(mkOp(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3));
        runOp(mkOp(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_FF00, 1));
        runOp(mkOp(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_FF00, 0));
        runOp(mkOp(1'b0, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 2));
        runOp(mkOp(1'b1, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0));
        runOp(mkOp(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h0, 0));
        runOp(mkOp(1'b1, 2'd2, 1'b0, 32'h400, 32'h0, 32'h1234_5678, TO + 5));
        runOp(mkOp(1'b1, 2'd1, 1'b0, 32'h402, 32'h0, 32'h8001_7FFF, TO - 1));

        // Reset in the middle of an outstanding request, then a late ack.
        @(negedge clk);
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2;
        ex_addr  = 32'h300; ex_dsel = 32'h4;
        #1;
        chk("mid_accept_stall", stall, 1);
        @(negedge clk);
        #1;
        chk("mid_req", bus.mem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        driveBubble();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("mid_req_dropped", bus.mem_req, 0);
        chk("mid_dsel", dsel_out, 32'h1);
        chk("mid_stall", stall, 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("late_ack_ignored", {dsel_out, 1'b0, load_out, store_out}, {32'h1, 3'b000});
        runOp(mkOp(1'b1, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0BAD_F00D, 1));

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 4);
            if (kind < 3) begin
                o = mkOp(kind == 0 || kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         $urandom, $urandom, $urandom, 0);
                if ($urandom_range(0, 3) != 0) begin
                    if (o.size == 2'd1) o.addr[0] = 1'b0;
                    if (o.size == 2'd2) o.addr[1:0] = 2'b00;
                end
                o.ackDelay = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1)
                                                         : $urandom_range(0, 3);
                runOp(o);
            end else begin
                runAlu(1'($urandom_range(0, 1)), $urandom, $urandom, 32'h1 << $urandom_range(0, 31));
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
